// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master: one bus cycle per command, with a response stream back.
// Optional macro WBM_ERR_EN adds wbm_err_i as a bus-error termination (err beats ack).
module wb_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_adr,
  input  logic [DW-1:0]   req_dat,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
`ifdef WBM_ERR_EN
  input  logic            wbm_err_i,
`endif
  input  logic [DW-1:0]   wbm_dat_i
);

  // A zero TIMEOUT still needs a legal one-bit counter; the compare is disabled then.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] tmo_cnt_r;
  logic          err_s;
  logic          tmo_s;

`ifdef WBM_ERR_EN
  assign err_s = wbm_err_i;
`else
  assign err_s = 1'b0;
`endif

  assign req_ready = (state_r == IDLE);

  // Abort fires on the BUS cycle whose increment would make the count reach TIMEOUT.
  always_comb begin
    tmo_s = 1'b0;
    if (TIMEOUT > 0) begin
      tmo_s = (tmo_cnt_r == CNT_LAST);
    end else begin
      tmo_s = 1'b0;
    end
  end

  // Command/bus/response sequencer with all outputs registered.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r   <= IDLE;
      tmo_cnt_r <= CNT_ZERO;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= {(DW/8){1'b0}};
      wbm_adr_o <= {AW{1'b0}};
      wbm_dat_o <= {DW{1'b0}};
      rsp_valid <= 1'b0;
      rsp_dat   <= {DW{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            wbm_we_o  <= req_we;
            wbm_adr_o <= req_adr;
            wbm_dat_o <= req_dat;
            wbm_sel_o <= req_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            tmo_cnt_r <= CNT_ZERO;
            state_r   <= BUS;
          end else begin
            state_r   <= IDLE;
          end
        end
        BUS: begin
          if (err_s) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= {DW{1'b0}};
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? {DW{1'b0}} : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else if (tmo_s) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= {DW{1'b0}};
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r   <= RESP;
          end
        end
        default: begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic single-transfer initiator (bus master).
- Converts a valid/ready command stream into one Wishbone read or write per command, then returns the read data and a status on a valid/ready response stream.
- Drives Wishbone slaves such as the user project's register file. Used by on-chip command sources (SPI bridge, test sequencer) that need to reach the slave bus.

Parameters:
- AW, 32, Wishbone address width.
- DW, 32, Wishbone data width (multiple of 8).
- TIMEOUT, 255, cycles in BUS without termination before abort; 0 disables the timeout.

Ports:
- wb_clk_i  input  1  clock; all logic on rising edge.
- wb_rst_ni  input  1  asynchronous, active-low reset.
- req_valid  input  1  command valid.
- req_ready  output  1  command accepted when req_valid && req_ready.
- req_we  input  1  1 = write, 0 = read.
- req_adr  input  AW  target address.
- req_dat  input  DW  write data.
- req_sel  input  DW/8  byte lane select.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_dat  output  DW  read data (0 for writes and errors).
- rsp_err  output  1  1 = timeout (or bus error, see Optional Feature).
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  DW/8  Wishbone byte selects.
- wbm_adr_o  output  AW  Wishbone address.
- wbm_dat_o  output  DW  Wishbone write data.
- wbm_ack_i  input  1  Wishbone acknowledge.
- wbm_dat_i  input  DW  Wishbone read data.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are registered and reset to 0. Exception: req_ready is 1 in IDLE, derived from state, so it reads 1 after reset.
- State machine has three states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, register we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, clear the timeout counter, go to BUS.
- BUS:
  - req_ready=0.
  - cyc, stb, adr, dat, sel and we are held stable.
  - Timeout counter (width $clog2(TIMEOUT+1)) increments each cycle ack is low.
  - On sampled ack=1: cyc=stb=0 next edge. rsp_dat=wbm_dat_i on a read, 0 on a write. rsp_err=0, rsp_valid=1. Go to RESP.
  - If counter reaches TIMEOUT with ack low: cyc=stb=0, rsp_dat=0, rsp_err=1, rsp_valid=1, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_dat and rsp_err are held until rsp_ready=1. At that edge rsp_valid=0 and the state returns to IDLE.
  - rsp_ready may be high on entry; RESP then lasts exactly one cycle.
- Latency: with ack returned in the first BUS cycle, rsp_valid rises 2 edges after the request handshake.
- Throughput: at most one transaction per 3 cycles (IDLE, BUS, RESP). Only one transfer is ever outstanding.
- wbm_ack_i in IDLE or RESP is ignored, with no state change.
- Non-BUS values: wbm_we_o/sel/adr/dat keep their last values outside BUS (don't-care to slaves). cyc and stb are 0 outside BUS.
- Reset mid-transaction: cyc and stb drop immediately (asynchronously) and any pending response is discarded.

Optional Feature:
- Macro: WBM_ERR_EN.
- Defined: adds input port wbm_err_i (1 bit). In BUS, err=1 terminates the cycle like ack but sets rsp_err=1 and rsp_dat=0. If ack and err are both high, err takes priority. err outside BUS is ignored.
- Undefined: no wbm_err_i port. rsp_err is set only by timeout.

Test Plan:
- Write: req we=1 adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF; slave acks in the 2nd BUS cycle -> cyc/stb high for exactly 2 cycles with stable adr/dat; rsp_valid, rsp_err=0, rsp_dat=0.
- Read: req we=0 adr=0x3000_0000; slave acks with dat=0x1234_5678 in the first BUS cycle, rsp_ready held 1 -> rsp_valid rises 2 edges after accept with rsp_dat=0x1234_5678, lasts 1 cycle; next req accepted the following cycle.
- Timeout: TIMEOUT=8, slave never acks -> cyc drops after 8 BUS cycles; rsp_err=1, rsp_dat=0; a stray ack afterwards is ignored.
- Backpressure: rsp_ready=0 for 5 cycles after a completed read -> rsp_valid/rsp_dat stable, req_ready=0 throughout; accept occurs only after rsp_ready.
- Reset mid-BUS: deassert wb_rst_ni while cyc=1 -> cyc/stb/rsp_valid go to 0 without waiting for a clock edge; after release, req_ready=1 and the next transaction completes normally.
- WBM_ERR_EN build: err=1 with ack=1 in the same cycle on a read -> rsp_err=1, rsp_dat=0.
